// File: rtl/delay_line_ram.sv
// Circular-buffer delay line on a simple dual-port RAM: each strobe writes din and returns the
// sample written `delay` strobes earlier. Optional macro DELAY_LINE_BYPASS_EN forwards din when delay is 0.
module delay_line_ram #(
  parameter int DATA_WIDTH = 9,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic [ADDR_WIDTH-1:0] delay,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  dout_valid,
  output logic                  primed
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] FILL_FULL = {1'b1, {ADDR_WIDTH{1'b0}}};

  logic [DATA_WIDTH-1:0] ram_r [DEPTH];

  logic [ADDR_WIDTH-1:0] wr_ptr_r;
  logic [ADDR_WIDTH:0]   fill_r;
  logic [DATA_WIDTH-1:0] dout_r;
  logic                  dout_valid_r;
  logic                  primed_r;

  logic [ADDR_WIDTH-1:0] rd_addr_s;
  logic [DATA_WIDTH-1:0] rd_data_s;
  logic                  real_s;
  logic                  delay_zero_s;
  logic                  wr_en_s;

  assign delay_zero_s = (delay == {ADDR_WIDTH{1'b0}});
  // Reset cycle never writes, so a strobe coinciding with reset leaves no trace.
  assign wr_en_s      = en & rst_n;

  // Read address trails the write pointer by `delay`, wrapping modulo depth.
  always_comb begin
    rd_addr_s = wr_ptr_r - delay;
  end

  // Decide whether this strobe returns a sample that was actually written since reset.
  always_comb begin
    real_s = 1'b0;
    if (delay_zero_s) begin
`ifdef DELAY_LINE_BYPASS_EN
      real_s = 1'b1;
`else
      // Read-before-write on the same slot: a full buffer lap of delay.
      real_s = (fill_r == FILL_FULL);
`endif
    end else begin
      real_s = (fill_r >= {1'b0, delay});
    end
  end

  // Select RAM data or, in the bypass build with zero delay, the incoming sample.
  always_comb begin
    rd_data_s = ram_r[rd_addr_s];
`ifdef DELAY_LINE_BYPASS_EN
    if (delay_zero_s) begin
      rd_data_s = din;
    end else begin
      rd_data_s = ram_r[rd_addr_s];
    end
`endif
  end

  // Sample storage; contents survive reset and are masked by the fill count instead.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      ram_r[wr_ptr_r] <= din;
    end
  end

  // Pointer, fill level and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_r     <= {ADDR_WIDTH{1'b0}};
      fill_r       <= {(ADDR_WIDTH+1){1'b0}};
      dout_r       <= {DATA_WIDTH{1'b0}};
      dout_valid_r <= 1'b0;
      primed_r     <= 1'b0;
    end else begin
      primed_r <= (fill_r == FILL_FULL);
      if (en) begin
        wr_ptr_r     <= wr_ptr_r + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
        dout_valid_r <= real_s;
        if (fill_r != FILL_FULL) begin
          fill_r <= fill_r + {{ADDR_WIDTH{1'b0}}, 1'b1};
        end
        if (real_s) begin
          dout_r <= rd_data_s;
        end else begin
          dout_r <= {DATA_WIDTH{1'b0}};
        end
      end else begin
        dout_valid_r <= 1'b0;
      end
    end
  end

  assign dout       = dout_r;
  assign dout_valid = dout_valid_r;
  assign primed     = primed_r;

endmodule

// File: tb/tb_delay_line_ram.sv
// Directed bench for delay_line_ram: a hand-computed vector table followed by
// multi-cycle sequences checked against a strobe-history reference model.
module tb_delay_line_ram;

  localparam int DW = 9;
  localparam int AW = 8;
  localparam int D  = 256;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          en;
  logic [DW-1:0] din;
  logic [AW-1:0] delay;
  logic [DW-1:0] dout;
  logic          dout_valid;
  logic          primed;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  delay_line_ram #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .din       (din),
    .delay     (delay),
    .dout      (dout),
    .dout_valid(dout_valid),
    .primed    (primed)
  );

  // Reference model: history of written samples indexed by strobe number since reset.
  logic [DW-1:0] hist [0:1023];
  int            k;
  logic [DW-1:0] m_dout;
  logic          m_valid;
  logic          m_primed;

  typedef struct {
    logic          rst_n;
    logic          en;
    logic [DW-1:0] din;
    logic [AW-1:0] delay;
    logic [DW-1:0] exp_dout;
    logic          exp_valid;
    logic          exp_primed;
  } vec_t;

  vec_t vecs [14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (strobe %0d)", name, act, exp, k);
    end
  endtask

  // Drive one cycle, update the model, and sample outputs 1 time unit after the edge.
  task automatic apply(input logic r, input logic e, input logic [DW-1:0] di, input logic [AW-1:0] dl);
    int   fill;
    logic v;
    rst_n = r;
    en    = e;
    din   = di;
    delay = dl;
    fill  = (k < D) ? k : D;
    if (!r) begin
      k        = 0;
      m_dout   = '0;
      m_valid  = 1'b0;
      m_primed = 1'b0;
    end else begin
      m_primed = (fill == D);
      if (e) begin
        if (dl == 8'd0) begin
`ifdef DELAY_LINE_BYPASS_EN
          v = 1'b1;
`else
          v = (fill == D);
`endif
        end else begin
          v = (fill >= int'(dl));
        end
        m_valid = v;
        if (!v) begin
          m_dout = '0;
        end else if (dl == 8'd0) begin
`ifdef DELAY_LINE_BYPASS_EN
          m_dout = di;
`else
          m_dout = hist[k - D];
`endif
        end else begin
          m_dout = hist[k - int'(dl)];
        end
        hist[k] = di;
        k++;
      end else begin
        m_valid = 1'b0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic apply_chk(input string name, input logic r, input logic e,
                           input logic [DW-1:0] di, input logic [AW-1:0] dl);
    apply(r, e, di, dl);
    chk({name, "_dout"},   32'(dout),       32'(m_dout));
    chk({name, "_valid"},  32'(dout_valid), 32'(m_valid));
    chk({name, "_primed"}, 32'(primed),     32'(m_primed));
  endtask

  initial begin
    rst_n = 1'b0;
    en    = 1'b0;
    din   = '0;
    delay = '0;
    k     = 0;

    // Reset with en toggling, then ramp with delay 3, gaps and delay changes.
    vecs[0]  = '{1'b0, 1'b1, 9'h055, 8'd3, 9'd0, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 1'b0, 9'h066, 8'd3, 9'd0, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, 1'b1, 9'd1,   8'd3, 9'd0, 1'b0, 1'b0};
    vecs[3]  = '{1'b1, 1'b1, 9'd2,   8'd3, 9'd0, 1'b0, 1'b0};
    vecs[4]  = '{1'b1, 1'b1, 9'd3,   8'd3, 9'd0, 1'b0, 1'b0};
    vecs[5]  = '{1'b1, 1'b1, 9'd4,   8'd3, 9'd1, 1'b1, 1'b0};
    vecs[6]  = '{1'b1, 1'b1, 9'd5,   8'd3, 9'd2, 1'b1, 1'b0};
    vecs[7]  = '{1'b1, 1'b0, 9'd9,   8'd3, 9'd2, 1'b0, 1'b0};
    vecs[8]  = '{1'b1, 1'b0, 9'd9,   8'd3, 9'd2, 1'b0, 1'b0};
    vecs[9]  = '{1'b1, 1'b1, 9'd6,   8'd3, 9'd3, 1'b1, 1'b0};
    vecs[10] = '{1'b1, 1'b1, 9'd7,   8'd1, 9'd6, 1'b1, 1'b0};
    vecs[11] = '{1'b1, 1'b1, 9'd8,   8'd7, 9'd1, 1'b1, 1'b0};
    vecs[12] = '{1'b1, 1'b1, 9'd9,   8'd9, 9'd0, 1'b0, 1'b0};
    vecs[13] = '{1'b1, 1'b0, 9'd0,   8'd9, 9'd0, 1'b0, 1'b0};

    for (int i = 0; i < 14; i++) begin
      apply(vecs[i].rst_n, vecs[i].en, vecs[i].din, vecs[i].delay);
      chk($sformatf("vec%0d_dout", i),   32'(dout),       32'(vecs[i].exp_dout));
      chk($sformatf("vec%0d_valid", i),  32'(dout_valid), 32'(vecs[i].exp_valid));
      chk($sformatf("vec%0d_primed", i), 32'(primed),     32'(vecs[i].exp_primed));
    end

    // Wrap-around with delay 255 over 600 continuous strobes.
    apply_chk("wrap_rst", 1'b0, 1'b0, 9'd0, 8'd255);
    for (int i = 0; i < 600; i++) begin
      apply_chk("wrap", 1'b1, 1'b1, 9'((i * 7 + 3) & 511), 8'd255);
      if (i == 255) chk("wrap_first_real", 32'(dout), 32'(3));
    end

    // Delay 0.
    apply_chk("d0_rst", 1'b0, 1'b0, 9'd0, 8'd0);
`ifdef DELAY_LINE_BYPASS_EN
    apply_chk("d0_byp", 1'b1, 1'b1, 9'h1A5, 8'd0);
    chk("d0_byp_hand", 32'(dout), 32'(9'h1A5));
    chk("d0_byp_hand_valid", 32'(dout_valid), 32'(1));
`else
    for (int i = 0; i < 257; i++) begin
      apply_chk("d0", 1'b1, 1'b1, 9'(i + 1), 8'd0);
      if (i == 254) chk("d0_primed_low", 32'(primed), 32'(0));
      if (i == 255) chk("d0_not_yet", 32'(dout_valid), 32'(0));
    end
    chk("d0_first_real", 32'(dout), 32'(1));
    chk("d0_first_valid", 32'(dout_valid), 32'(1));
    chk("d0_primed_high", 32'(primed), 32'(1));
`endif

    // Gapped strobes (every 3rd cycle) with delay 10 -> 4 change.
    apply_chk("gap_rst", 1'b0, 1'b0, 9'd0, 8'd10);
    for (int i = 0; i < 24; i++) begin
      apply_chk("gap", 1'b1, 1'b1, 9'(100 + i), (i < 20) ? 8'd10 : 8'd4);
      if (i == 19) chk("gap_d10", 32'(dout), 32'(109));
      if (i == 20) chk("gap_d4", 32'(dout), 32'(116));
      apply_chk("gap_hold1", 1'b1, 1'b0, 9'h1FF, 8'd4);
      apply_chk("gap_hold2", 1'b1, 1'b0, 9'h1FF, 8'd4);
    end

    // Mid-operation reset after 300 strobes of a stale marker value.
    apply_chk("mid_rst0", 1'b0, 1'b0, 9'd0, 8'd5);
    for (int i = 0; i < 300; i++) begin
      apply_chk("mid_fill", 1'b1, 1'b1, 9'h1EE, 8'd5);
    end
    chk("mid_primed_before", 32'(primed), 32'(1));
    apply_chk("mid_rst", 1'b0, 1'b1, 9'h0AA, 8'd5);
    chk("mid_rst_dout", 32'(dout), 32'(0));
    chk("mid_rst_primed", 32'(primed), 32'(0));
    for (int i = 0; i < 8; i++) begin
      apply_chk("mid_after", 1'b1, 1'b1, 9'(i + 1), 8'd5);
      if (i < 5) chk("mid_no_stale", 32'(dout), 32'(0));
      if (i == 5) chk("mid_first_real", 32'(dout), 32'(1));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/delay_line_ram.md
# delay_line_ram

Parametrised circular-buffer delay line built on a simple dual-port RAM. Each sample strobe writes one input sample and reads back the sample written `delay` strobes earlier. The read and write addresses are generated internally from a single write pointer. It sits between the sample-rate counter and the DAC/output path of the signal generator, and provides run-time-adjustable delay/phase offset without an external address counter.

## Interface
- `DATA_WIDTH`, 9, sample width in bits
- `ADDR_WIDTH`, 8, log2 of buffer depth; depth D = 2**ADDR_WIDTH
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  synchronous active-low reset; one clock, synchronous, active-low
- `en`  in  1  sample strobe; one write and one read per cycle `en`=1
- `din`  in  DATA_WIDTH  sample to store
- `delay`  in  ADDR_WIDTH  delay in strobes, sampled every strobe
- `dout`  out  DATA_WIDTH  delayed sample, registered
- `dout_valid`  out  1  one-cycle pulse: `dout` was just updated with a real, previously written sample
- `primed`  out  1  level: buffer has received at least D strobes since reset

## Operation
- State: `wr_ptr` (ADDR_WIDTH bits); `fill` (ADDR_WIDTH+1 bits, saturating at D); RAM array D x DATA_WIDTH, not reset.
- On a cycle with `en`=1:
  - `ram[wr_ptr] <= din`
  - rd_addr = (`wr_ptr` - `delay`) mod D, unsigned wrap
  - `dout <= ram[rd_addr]` (or bypass, see Configuration)
  - `wr_ptr <= wr_ptr + 1` mod D
  - `fill <= min(fill + 1, D)`
- Strobe k counts from 0 after reset, with `fill` = k (saturated) when it is sampled.
- Sample validity at strobe k with delay d:
  - d ≥ 1: real iff `fill` ≥ d.
  - d = 0: see Configuration.
- Non-real sample: `dout <= 0`, `dout_valid` = 0 next cycle.
- Real sample: `dout` gets RAM/bypass data, `dout_valid` = 1 next cycle.
- `en`=0: no write, no pointer or `fill` change, `dout` holds, `dout_valid` = 0.
- `primed` = (`fill` == D), registered.
- `delay` may change on any cycle. The new value applies from the next strobe; there is no flush, and already-written data is reused.
- Reset (any cycle, including mid-operation):
  - `wr_ptr`=0, `fill`=0, `dout`=0, `dout_valid`=0, `primed`=0.
  - RAM contents are retained but treated as unwritten through the `fill` gating.
  - `en` is ignored in the reset cycle.

## Timing
- Read latency: 1 clock. `dout` and `dout_valid` reflect the strobe sampled at the previous rising edge.
- Back-to-back strobes every cycle are supported: throughput is 1 sample per clock.
- For d in 1..D-1, read and write addresses never collide. Read data is the value written d strobes earlier.
- `dout_valid` is high for exactly one cycle per qualifying strobe and is never high without a strobe in the preceding cycle.
- `primed` rises in the cycle after the D-th strobe and stays high until reset.

## Configuration
- Macro: `DELAY_LINE_BYPASS_EN`.
- Defined, d = 0:
  - Same-address read-during-write forwards `din`, so `dout` equals the current input one cycle later.
  - The sample is always real.
- Undefined, d = 0:
  - Read-before-write: `dout` returns the old RAM content, i.e. a delay of D strobes.
  - The sample is real iff `fill` == D.
- Behaviour for d ≥ 1 is identical in both builds.

## Test plan
- Reset values: hold `rst_n`=0 for 2 cycles -> `dout`=0, `dout_valid`=0, `primed`=0, and no change while `en` toggles during reset.
- Ramp, delay=3, `en` every cycle, `din`=1,2,3,…:
  - strobes 0–2 -> `dout`=0, `dout_valid`=0
  - strobe 3 -> `dout`=1
  - strobe 4 -> `dout`=2
- Delay 0 with D=256:
  - with macro: `din`=0x1A5 -> next cycle `dout`=0x1A5, `dout_valid`=1
  - without macro, ramp: first real output at strobe 256 = 1; `primed` high from the cycle after strobe 256
- Wrap-around, delay=255, 600 continuous strobes -> `dout` at strobe k = `din` of strobe k-255 across `wr_ptr` wrap; no glitch at `wr_ptr` 255→0.
- Gapped strobes and delay change:
  - `en` every 3rd cycle -> `dout` holds between strobes.
  - Delay 10→4 mid-stream -> next strobe returns the sample from 4 strobes earlier.
- Mid-operation reset after 300 strobes:
  - -> all outputs 0.
  - Then delay=5: first 5 strobes `dout_valid`=0; stale RAM data never appears.
